// File: rtl/pc_unit_if.sv
// Handshake bundle between the control path and the program-counter unit.
// The master drives the update requests; the slave (pc_unit) returns the registered PC state.
interface pc_unit_if #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned CNT_WIDTH = 32
);
  logic                 pc_write;
  logic                 pc_write_cond;
  logic                 branch_ne;
  logic                 alu_zero;
  logic [WIDTH-1:0]     pc_in;
  logic                 stall;
  logic                 exc_req;
  logic                 epc_restore;
  logic [WIDTH-1:0]     pc_out;
  logic [WIDTH-1:0]     pc_prev;
  logic [WIDTH-1:0]     epc;
  logic                 misalign;
  logic [CNT_WIDTH-1:0] update_count;

  modport master (
    output pc_write, pc_write_cond, branch_ne, alu_zero, pc_in,
           stall, exc_req, epc_restore,
    input  pc_out, pc_prev, epc, misalign, update_count
  );

  modport slave (
    input  pc_write, pc_write_cond, branch_ne, alu_zero, pc_in,
           stall, exc_req, epc_restore,
    output pc_out, pc_prev, epc, misalign, update_count
  );
endinterface

// File: rtl/pc_unit.sv
// Program counter for the multicycle datapath: unconditional/branch writes, alignment
// trap, exception redirect with EPC save/restore, previous-PC and update counter.
module pc_unit #(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [31:0]      EXC_VECTOR   = 32'h8000_0180,
  parameter int unsigned      ALIGN_BITS   = 2,
  parameter int unsigned      CNT_WIDTH    = 32
) (
  input logic        clk,
  input logic        reset_n,
  pc_unit_if.slave   bus
);

  localparam logic [WIDTH-1:0] EXC_TARGET = WIDTH'(EXC_VECTOR);

  logic [WIDTH-1:0]     r_pc;
  logic [WIDTH-1:0]     r_pc_prev;
  logic [WIDTH-1:0]     r_epc;
  logic                 r_misalign;
  logic [CNT_WIDTH-1:0] r_update_count;

  logic w_take;
  logic w_bad_addr;

  assign w_take = bus.pc_write | (bus.pc_write_cond & (bus.alu_zero ^ bus.branch_ne));

  if (ALIGN_BITS > 0) begin : g_align
    assign w_bad_addr = |bus.pc_in[ALIGN_BITS-1:0];
  end else begin : g_no_align
    assign w_bad_addr = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pc           <= RESET_VECTOR;
      r_pc_prev      <= RESET_VECTOR;
      r_epc          <= '0;
      r_misalign     <= 1'b0;
      r_update_count <= '0;
    end else begin
      r_misalign <= 1'b0;
      // Exception outranks stall; stall in turn freezes restore and branch writes.
      if (bus.exc_req) begin
        r_epc          <= r_pc;
        r_pc           <= EXC_TARGET;
        r_pc_prev      <= r_pc;
        r_update_count <= r_update_count + CNT_WIDTH'(1);
      end else if (!bus.stall) begin
        if (bus.epc_restore) begin
          r_pc           <= r_epc;
          r_pc_prev      <= r_pc;
          r_update_count <= r_update_count + CNT_WIDTH'(1);
        end else if (w_take) begin
          if (w_bad_addr) begin
            r_misalign <= 1'b1;
          end else begin
            r_pc           <= bus.pc_in;
            r_pc_prev      <= r_pc;
            r_update_count <= r_update_count + CNT_WIDTH'(1);
          end
        end
      end
    end
  end

  assign bus.pc_out       = r_pc;
  assign bus.pc_prev      = r_pc_prev;
  assign bus.epc          = r_epc;
  assign bus.misalign     = r_misalign;
  assign bus.update_count = r_update_count;

endmodule
